// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle core: sequences fetch/decode/execute and
// issues datapath selects plus the PCS/RegW/MemW/FlagW requests to the condition unit.
module multicycle_ctrl_fsm #(
    parameter bit FETCH_WAIT_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MemReady,
    output logic [3:0] State,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_t     state;
    logic       mem_ready;
    logic [3:0] cmd;
    logic       is_cmp;
    logic       set_flags;
    logic       pc_is_dest;
    logic [1:0] alu_dec;

    assign State      = state;
    assign mem_ready  = FETCH_WAIT_EN ? MemReady : 1'b1;
    assign cmd        = Funct[4:1];
    assign set_flags  = Funct[0];
    assign is_cmp     = (cmd == 4'b1010);
    assign pc_is_dest = (Rd == 4'b1111);

    always_comb begin
        case (cmd)
            4'b0100: alu_dec = ALU_ADD;
            4'b0010: alu_dec = ALU_SUB;
            4'b0000: alu_dec = ALU_AND;
            4'b1100: alu_dec = ALU_ORR;
            4'b1010: alu_dec = ALU_SUB;
            default: alu_dec = ALU_ADD;
        endcase
    end

    // Unused encodings (10-15) fall into the default arm and recover to FETCH.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (Op)
                        2'b01:   state <= S_MEMADR;
                        2'b00:   state <= Funct[5] ? S_EXECI : S_EXECR;
                        2'b10:   state <= S_BRANCH;
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR: state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR:  state <= mem_ready ? S_FETCH : S_MEMWR;
                S_EXECR,
                S_EXECI:  state <= is_cmp ? S_FETCH : S_ALUWB;
                S_ALUWB:  state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Outputs follow the current state and instruction fields; Reset masks every strobe.
    always_comb begin
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'd0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ALUControl = ALU_ADD;
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        FlagW      = 2'b00;
        case (state)
            S_FETCH: begin
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
            end
            S_MEMADR: begin
                ALUSrcB = 2'd1;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'd1;
                RegW      = 1'b1;
                PCS       = pc_is_dest;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECR,
            S_EXECI: begin
                ALUSrcB    = (state == S_EXECI) ? 2'd1 : 2'd0;
                ALUControl = alu_dec;
                if (is_cmp) begin
                    FlagW = 2'b11;
                end else begin
                    FlagW[1] = set_flags;
                    FlagW[0] = set_flags && (alu_dec == ALU_ADD || alu_dec == ALU_SUB);
                end
            end
            S_ALUWB: begin
                RegW = 1'b1;
                PCS  = pc_is_dest;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                PCS       = 1'b1;
            end
            default: ;
        endcase
        if (Reset) begin
            IRWrite = 1'b0;
            NextPC  = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            PCS     = 1'b0;
            FlagW   = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: walks each instruction class cycle by
// cycle and compares state and control outputs to hand-derived values.
module tb_multicycle_ctrl_fsm;

    logic       CLK;
    logic       Reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemReady;
    logic [3:0] State;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [1:0] FlagW;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl_fsm #(.FETCH_WAIT_EN(1'b1)) dut (
        .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .MemReady(MemReady), .State(State), .IRWrite(IRWrite), .NextPC(NextPC),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one clock; inputs are changed and outputs sampled mid-low phase.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        Reset = 1'b0; Op = 2'b00; Funct = 6'b001001; Rd = 4'd2; MemReady = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if (State !== 4'd6) begin errors++; $display("[TB] FAIL reset_reach_execr: State=%0d expected 6", State); end
        Reset = 1'b1;
        #1;
        checks++;
        if (FlagW !== 2'b00 || RegW !== 1'b0 || PCS !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mask_execr: FlagW=%b RegW=%b PCS=%b expected 00 0 0", FlagW, RegW, PCS);
        end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            checks++;
            if (State !== 4'd0 || IRWrite !== 1'b0 || NextPC !== 1'b0 || MemW !== 1'b0 || FlagW !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_hold%0d: State=%0d IRWrite=%b NextPC=%b MemW=%b FlagW=%b expected 0 0 0 0 00",
                         i, State, IRWrite, NextPC, MemW, FlagW);
            end
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (IRWrite !== 1'b1 || NextPC !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_release_fetch: IRWrite=%b NextPC=%b expected 1 1", IRWrite, NextPC);
        end
        tick(); #1;
        checks++;
        if (State !== 4'd1) begin errors++; $display("[TB] FAIL reset_to_decode: State=%0d expected 1", State); end
        Reset = 1'b1; tick(); Reset = 1'b0;
    endtask

    task automatic test_ldr();
        logic [3:0] exp_state [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [1:0] exp_res   [6] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
        logic       exp_adr   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd3; MemReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (State !== exp_state[i] || ResultSrc !== exp_res[i] || AdrSrc !== exp_adr[i] ||
                RegW !== (i == 4) || PCS !== 1'b0 || MemW !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ldr_cyc%0d: State=%0d ResultSrc=%0d AdrSrc=%b RegW=%b PCS=%b MemW=%b expected %0d %0d %b %b 0 0",
                         i, State, ResultSrc, AdrSrc, RegW, PCS, MemW, exp_state[i], exp_res[i], exp_adr[i], (i == 4));
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_str();
        logic [3:0] exp_state [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        int memw_cycles = 0;
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd4; MemReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            MemReady = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            #1;
            if (MemW === 1'b1) memw_cycles++;
            checks++;
            if (State !== exp_state[i] || RegW !== 1'b0 || MemW !== (i >= 3 && i <= 6)) begin
                errors++;
                $display("[TB] FAIL str_cyc%0d: State=%0d RegW=%b MemW=%b expected %0d 0 %b",
                         i, State, RegW, MemW, exp_state[i], (i >= 3 && i <= 6));
            end
            if (i < 7) tick();
        end
        checks++;
        if (memw_cycles != 4) begin errors++; $display("[TB] FAIL str_memw_count: got %0d expected 4", memw_cycles); end
        MemReady = 1'b1;
    endtask

    task automatic test_dp();
        Op = 2'b00; Funct = 6'b001001; Rd = 4'd15; MemReady = 1'b1;
        tick(); tick(); #1;
        checks++;
        if (State !== 4'd6 || ALUControl !== 2'b00 || FlagW !== 2'b11 || ALUSrcB !== 2'd0 || ALUSrcA !== 2'd0) begin
            errors++;
            $display("[TB] FAIL adds_execr: State=%0d ALUControl=%b FlagW=%b ALUSrcB=%0d ALUSrcA=%0d expected 6 00 11 0 0",
                     State, ALUControl, FlagW, ALUSrcB, ALUSrcA);
        end
        tick(); #1;
        checks++;
        if (State !== 4'd8 || RegW !== 1'b1 || PCS !== 1'b1 || ResultSrc !== 2'd0 || FlagW !== 2'b00) begin
            errors++;
            $display("[TB] FAIL adds_aluwb: State=%0d RegW=%b PCS=%b ResultSrc=%0d FlagW=%b expected 8 1 1 0 00",
                     State, RegW, PCS, ResultSrc, FlagW);
        end
        tick(); #1;
        checks++;
        if (State !== 4'd0) begin errors++; $display("[TB] FAIL adds_return: State=%0d expected 0", State); end
    endtask

    task automatic test_exec_decode();
        logic [5:0] funct_v [6] = '{6'b111001, 6'b010101, 6'b010100, 6'b000100, 6'b000001, 6'b111111};
        logic [3:0] exec_st [6] = '{4'd7,      4'd6,      4'd6,      4'd6,      4'd6,      4'd7};
        logic [1:0] alu_v   [6] = '{2'b11,     2'b01,     2'b01,     2'b01,     2'b10,     2'b00};
        logic [1:0] flag_v  [6] = '{2'b10,     2'b11,     2'b11,     2'b00,     2'b10,     2'b11};
        logic [3:0] next_st [6] = '{4'd8,      4'd0,      4'd0,      4'd8,      4'd8,      4'd8};
        Op = 2'b00; Rd = 4'd1; MemReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            Funct = funct_v[k];
            tick(); tick(); #1;
            checks++;
            if (State !== exec_st[k] || ALUControl !== alu_v[k] || FlagW !== flag_v[k] || RegW !== 1'b0 ||
                ALUSrcB !== ((exec_st[k] == 4'd7) ? 2'd1 : 2'd0)) begin
                errors++;
                $display("[TB] FAIL exec_f%b: State=%0d ALUControl=%b FlagW=%b RegW=%b ALUSrcB=%0d expected %0d %b %b 0",
                         funct_v[k], State, ALUControl, FlagW, RegW, ALUSrcB, exec_st[k], alu_v[k], flag_v[k]);
            end
            tick(); #1;
            checks++;
            if (State !== next_st[k] || PCS !== 1'b0) begin
                errors++;
                $display("[TB] FAIL exec_next_f%b: State=%0d PCS=%b expected %0d 0", funct_v[k], State, PCS, next_st[k]);
            end
            if (next_st[k] != 4'd0) tick();
        end
    endtask

    task automatic test_branch();
        logic [3:0] exp_state [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
        Op = 2'b10; Funct = 6'b000000; Rd = 4'd0; MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (State !== exp_state[i] || PCS !== (i == 2) ||
                (i == 2 && (ALUSrcB !== 2'd1 || ALUSrcA !== 2'd0 || ResultSrc !== 2'd2 || ALUControl !== 2'b00))) begin
                errors++;
                $display("[TB] FAIL branch_cyc%0d: State=%0d PCS=%b ALUSrcB=%0d ALUSrcA=%0d ResultSrc=%0d expected %0d %b",
                         i, State, PCS, ALUSrcB, ALUSrcA, ResultSrc, exp_state[i], (i == 2));
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_undefined();
        Op = 2'b11; Funct = 6'b000000; Rd = 4'd15; MemReady = 1'b1;
        tick(); #1;
        checks++;
        if (State !== 4'd1 || ALUSrcA !== 2'd1 || ALUSrcB !== 2'd2) begin
            errors++; $display("[TB] FAIL undef_decode: State=%0d ALUSrcA=%0d ALUSrcB=%0d expected 1 1 2", State, ALUSrcA, ALUSrcB);
        end
        tick(); #1;
        checks++;
        if (State !== 4'd0 || RegW !== 1'b0 || PCS !== 1'b0) begin
            errors++; $display("[TB] FAIL undef_return: State=%0d RegW=%b PCS=%b expected 0 0 0", State, RegW, PCS);
        end
    endtask

    task automatic test_fetch_stall();
        Op = 2'b10; Funct = 6'b000000; Rd = 4'd0;
        MemReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (State !== 4'd0 || IRWrite !== 1'b0 || NextPC !== 1'b0 || ALUSrcB !== 2'd2) begin
                errors++;
                $display("[TB] FAIL stall_cyc%0d: State=%0d IRWrite=%b NextPC=%b ALUSrcB=%0d expected 0 0 0 2",
                         i, State, IRWrite, NextPC, ALUSrcB);
            end
            tick();
        end
        MemReady = 1'b1;
        #1;
        checks++;
        if (State !== 4'd0 || IRWrite !== 1'b1 || NextPC !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_release: State=%0d IRWrite=%b NextPC=%b expected 0 1 1", State, IRWrite, NextPC);
        end
        tick(); #1;
        checks++;
        if (State !== 4'd1) begin errors++; $display("[TB] FAIL stall_to_decode: State=%0d expected 1", State); end
        tick(); tick();
    endtask

    task automatic test_ldr_pc_dest();
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd15; MemReady = 1'b1;
        tick(); tick(); tick(); tick(); #1;
        checks++;
        if (State !== 4'd4 || PCS !== 1'b1 || RegW !== 1'b1) begin
            errors++; $display("[TB] FAIL ldr_pc_memwb: State=%0d PCS=%b RegW=%b expected 4 1 1", State, PCS, RegW);
        end
        tick();
    endtask

    initial begin
        Reset = 1'b1; Op = 2'b00; Funct = 6'b000000; Rd = 4'd0; MemReady = 1'b1;
        tick(); tick();
        test_reset();
        test_ldr();
        test_str();
        test_dp();
        test_exec_decode();
        test_branch();
        test_undefined();
        test_fetch_stall();
        test_ldr_pc_dest();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle core; the producing end of the conditional-execution interface.
- Each cycle it generates the PCS, RegW, MemW and FlagW strobes, which the condition unit then gates with the condition check.
- It also drives the datapath selects and handles the memory-ready handshake.
- Instruction fields come from the instruction register, which is loaded under this block's IRWrite.

Parameters:
FETCH_WAIT_EN, 1, 1 = FETCH/MEMRD/MEMWR wait for MemReady; 0 = MemReady treated as constantly 1

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  synchronous, active-high
Op  input  2  Instr[27:26]
Funct  input  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (DP) or L (mem)
Rd  input  4  Instr[15:12]
MemReady  input  1  memory has completed the current access this cycle
State  output  4  current state encoding (debug/verification)
IRWrite  output  1  load instruction register
NextPC  output  1  update PC
AdrSrc  output  1  0 = PC, 1 = ALU result to memory address
ResultSrc  output  2  0 = ALUOut, 1 = read data, 2 = ALU result direct
ALUSrcA  output  2  0 = RD1, 1 = PC
ALUSrcB  output  2  0 = RD2, 1 = ExtImm, 2 = constant 4
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
PCS  output  1  PC-source request (to condition unit)
RegW  output  1  register-write request (to condition unit)
MemW  output  1  memory-write request (to condition unit)
FlagW  output  2  [1] = N/Z write, [0] = C/V write (to condition unit)

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high.
  - Reset high at a rising edge sets State to FETCH, regardless of the current state (mid-instruction reset aborts it).
  - While Reset is high, IRWrite, NextPC, RegW, MemW, PCS and FlagW are forced to 0.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9.
  - Codes 10–15 go to FETCH on the next edge with all strobes 0.
- Outputs are combinational from State plus the instruction fields. Unlisted selects are 0 and unlisted strobes are 0.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ALUControl=ADD, ResultSrc=2.
  - IRWrite = NextPC = MemReady.
  - Advance to DECODE only when MemReady=1; otherwise stay in FETCH.
- DECODE: ALUSrcA=1, ALUSrcB=2, ResultSrc=2. Next state:
  - Op=01 → MEMADR
  - Op=00 and Funct[5]=0 → EXECR
  - Op=00 and Funct[5]=1 → EXECI
  - Op=10 → BRANCH
  - Op=11 → FETCH (undefined, executes as NOP)
- MEMADR: ALUSrcA=0, ALUSrcB=1, ADD. Funct[0]=1 → MEMRD, else → MEMWR.
- MEMRD: AdrSrc=1. Stay until MemReady, then → MEMWB.
- MEMWB: ResultSrc=1, RegW=1, then → FETCH.
- MEMWR: AdrSrc=1, MemW=1 for every cycle in this state. Stay until MemReady, then → FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=0. EXECI: ALUSrcA=0, ALUSrcB=1.
  - Both decode ALUControl from cmd: 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, 1010 (CMP)→SUB, any other→ADD.
  - FlagW[1] = S.
  - FlagW[0] = S and (ALUControl is ADD or SUB).
  - CMP forces FlagW=11 regardless of S and then → FETCH (no writeback). All other cmds → ALUWB.
- ALUWB: ResultSrc=0, RegW=1, then → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=1, ADD, ResultSrc=2, PCS=1, then → FETCH.
- PCS is also 1 in ALUWB and MEMWB when Rd=1111.
- FlagW is 00 in every state other than EXECR/EXECI.
- Latency in cycles, with MemReady=1 throughout:
  - LDR 5
  - STR 4
  - DP 4
  - CMP 3
  - B 3
  - Undefined 2
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Op/Funct/Rd must be stable from DECODE until the return to FETCH; the block does not latch them.

Test Plan:
- Reset held 2 cycles mid-EXECR, then released → State=0 on the first edge with Reset high; strobes 0 throughout; FETCH active after release.
- LDR (Op=01, Funct=011001, Rd=3), MemReady=1 → State 0,1,2,3,4,0; RegW=1 and ResultSrc=1 only in MEMWB; PCS=0.
- STR (Op=01, Funct=011000), MemReady=0 for 3 cycles in MEMWR → MemW=1 for 4 cycles; State=5 held; then FETCH; RegW never 1.
- ADDS register (Op=00, Funct=001001, Rd=15) → EXECR has ALUControl=00 and FlagW=11; ALUWB has RegW=1 and PCS=1.
- ORRS imm (Funct=111001) → FlagW=10; CMP (Funct=010101) → FlagW=11, State 6→0, no RegW.
- B (Op=10) → State 0,1,9,0; PCS=1, ALUSrcB=1 in BRANCH. FETCH with MemReady=0 → IRWrite=0, NextPC=0, State held at 0.
